// File: rtl/ps2_pkg.sv
// Shared constants, decoder states and event record for the PS/2 key controller.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Bytes of the Pause sequence that follow the leading E1.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXTBRK,
    PAUSE
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic is_kbd_err(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_evfifo.sv
// Synchronous show-ahead FIFO; head entry visible on rdat whenever not empty.
// Latency: a push is visible at the head one cycle later; pop exposes the next entry the next cycle.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module ps2_evfifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdat,
  input  logic             pop,
  output logic [WIDTH-1:0] rdat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdat    = mem[rd_ptr];

  always_ff @(posedge clkin) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clkin) begin
    if (do_push) mem[wr_ptr] <= wdat;
  end

endmodule

// File: rtl/ps2_keyctl.sv
// Collapses PS/2 set-2 scancode sequences into key events queued in a show-ahead FIFO.
// Latency: event visible on key_* one cycle after its final byte is accepted.
// Backpressure: never stalls the receiver; events arriving at a full FIFO are dropped and flagged.
module ps2_keyctl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic [7:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  input  logic       stat_clr,
  output logic       stat_overflow,
  output logic       stat_kbd_err
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          byte_acc, ev_vld, err_set, ovf_set, pop;
  logic          fifo_full, fifo_empty;
  ps2_event_t    ev, head;

  assign byte_acc = sym_valid & sym_ready;
  assign pop      = key_valid & key_ready;
  assign ovf_set  = ev_vld & fifo_full & ~pop;

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q       <= IDLE;
      skip_q        <= '0;
      timer_q       <= '0;
      sym_ready     <= 1'b0;
      stat_overflow <= 1'b0;
      stat_kbd_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      timer_q   <= timer_d;
      sym_ready <= 1'b1;
      // A new error in the clearing cycle must not be lost.
      if (ovf_set)       stat_overflow <= 1'b1;
      else if (stat_clr) stat_overflow <= 1'b0;
      if (err_set)       stat_kbd_err  <= 1'b1;
      else if (stat_clr) stat_kbd_err  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    timer_d = timer_q;
    ev_vld  = 1'b0;
    ev      = '0;
    err_set = 1'b0;
    if (byte_acc) begin
      timer_d = '0;
      if (is_kbd_err(sym_data)) begin
        err_set = 1'b1;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (sym_data == PS2_EXT)        state_d = EXT;
            else if (sym_data == PS2_BRK)   state_d = BRK;
            else if (sym_data == PS2_PAUSE) begin
              state_d = PAUSE;
              skip_d  = PAUSE_SKIP;
            end else if (!(sym_data inside {PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RESEND})) begin
              ev_vld = 1'b1;
              ev     = '{ext: 1'b0, brk: 1'b0, code: sym_data};
            end
          end
          EXT: begin
            if (sym_data == PS2_BRK) state_d = EXTBRK;
            else if (sym_data != PS2_EXT) begin
              ev_vld  = 1'b1;
              ev      = '{ext: 1'b1, brk: 1'b0, code: sym_data};
              state_d = IDLE;
            end
          end
          BRK: begin
            ev_vld  = 1'b1;
            ev      = '{ext: 1'b0, brk: 1'b1, code: sym_data};
            state_d = IDLE;
          end
          EXTBRK: begin
            ev_vld  = 1'b1;
            ev      = '{ext: 1'b1, brk: 1'b1, code: sym_data};
            state_d = IDLE;
          end
          PAUSE: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
              ev_vld  = 1'b1;
              ev      = '{ext: 1'b1, brk: 1'b0, code: PS2_PAUSE};
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q == IDLE) begin
      timer_d = '0;
    end else if (timer_q == TIMER_MAX) begin
      timer_d = '0;
      state_d = IDLE;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  ps2_evfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_evfifo (
    .clkin (clkin),
    .rst   (rst),
    .push  (ev_vld),
    .wdat  (ev),
    .pop   (pop),
    .rdat  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign key_valid = ~fifo_empty;
  assign key_code  = key_valid ? head.code : 8'h00;
  assign key_ext   = key_valid & head.ext;
  assign key_break = key_valid & head.brk;

endmodule

// File: tb/tb_ps2_keyctl.sv
// Self-checking bench for ps2_keyctl: directed vector table, corner sequences and random traffic vs a reference model.
module tb_ps2_keyctl;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sym_data = 8'h00;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid;
  logic       key_ready = 1'b0;
  logic       stat_clr = 1'b0;
  logic       stat_overflow, stat_kbd_err;

  always #5 clkin = ~clkin;

  ps2_keyctl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clkin(clkin), .rst(rst), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_valid(key_valid), .key_ready(key_ready),
    .stat_clr(stat_clr), .stat_overflow(stat_overflow), .stat_kbd_err(stat_kbd_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending prefix bytes, event queue, flags, cycle stamps.
  logic [9:0] mq[$];
  logic [7:0] pend[$];
  bit         m_rdy = 0, m_ovf = 0, m_kerr = 0;
  int         cyc = 0, last_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pend_has(input logic [7:0] b);
    foreach (pend[i]) if (pend[i] == b) return 1;
    return 0;
  endfunction

  // Interprets the byte against the prefix collected so far.
  task automatic model_byte(input logic [7:0] b, output bit evv, output logic [9:0] ev, output bit err);
    bit e0, f0;
    evv = 0; ev = '0; err = 0;
    if (b == 8'h00 || b == 8'hFF) begin
      err = 1; pend.delete(); return;
    end
    if (pend.size() > 0 && pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin evv = 1; ev = {2'b10, 8'hE1}; pend.delete(); end
      return;
    end
    e0 = pend_has(8'hE0);
    f0 = pend_has(8'hF0);
    if (f0) begin
      evv = 1; ev = {e0, 1'b1, b}; pend.delete();
    end else if (b == 8'hE0 || b == 8'hF0) begin
      pend.push_back(b);
    end else if (pend.size() == 0 && b == 8'hE1) begin
      pend.push_back(b);
    end else if (pend.size() == 0 && (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin
      // discarded
    end else begin
      evv = 1; ev = {e0, 1'b0, b}; pend.delete();
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit r, input bit c, input bit rs);
    bit acc, pop, evv, err, oset;
    logic [9:0] ev;
    cyc++;
    if (rs) begin
      mq.delete(); pend.delete(); m_rdy = 0; m_ovf = 0; m_kerr = 0; last_cyc = cyc;
      return;
    end
    acc = v && m_rdy;
    pop = (mq.size() > 0) && r;
    evv = 0; err = 0; oset = 0; ev = '0;
    if (acc) begin
      if (cyc - last_cyc > TMO) pend.delete();
      model_byte(d, evv, ev, err);
      last_cyc = cyc;
    end
    if (pop) void'(mq.pop_front());
    if (evv) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else oset = 1;
    end
    if (oset) m_ovf = 1; else if (c) m_ovf = 0;
    if (err) m_kerr = 1; else if (c) m_kerr = 0;
    m_rdy = 1;
  endtask

  task automatic compare_model();
    check("sym_ready", sym_ready, m_rdy);
    check("key_valid", key_valid, mq.size() > 0);
    if (mq.size() > 0) check("head", {key_ext, key_break, key_code}, mq[0]);
    check("stat_overflow", stat_overflow, m_ovf);
    check("stat_kbd_err", stat_kbd_err, m_kerr);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit c, input bit rs);
    @(negedge clkin);
    sym_valid = v; sym_data = d; key_ready = r; stat_clr = c; rst = rs;
    @(posedge clkin);
    model_edge(v, d, r, c, rs);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         clr;
    bit         e_vld;
    logic [9:0] e_ev;
    bit         e_kerr;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_d [DEPTH];
  logic [7:0] pool [12];

  initial begin
    // Reset state
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_fields", {key_ext, key_break, key_code}, 10'h000);
    check("rst_flags", {stat_overflow, stat_kbd_err}, 2'b00);
    step(0, 8'h00, 1, 0, 0);
    check("sym_ready_after_rst", sym_ready, 1);

    // Directed vectors, key_ready held high: {v, byte, clr, exp valid, exp {ext,brk,code}, exp kbd_err}
    tbl.push_back(vec_t'{1, 8'h1C, 0, 1, 10'h01C, 0});
    tbl.push_back(vec_t'{1, 8'hF0, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'h1C, 0, 1, 10'h11C, 0});
    tbl.push_back(vec_t'{1, 8'hE0, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'h75, 0, 1, 10'h275, 0});
    tbl.push_back(vec_t'{1, 8'hE0, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'hF0, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'h75, 0, 1, 10'h375, 0});
    tbl.push_back(vec_t'{1, 8'hE0, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'hE0, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'h75, 0, 1, 10'h275, 0});
    tbl.push_back(vec_t'{1, 8'hAA, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'hFA, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'hFF, 0, 0, 10'h000, 1});
    tbl.push_back(vec_t'{0, 8'h00, 1, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'hE1, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'h14, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'h77, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'hE1, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'hF0, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'h14, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'hF0, 0, 0, 10'h000, 0});
    tbl.push_back(vec_t'{1, 8'h77, 0, 1, 10'h2E1, 0});
    tbl.push_back(vec_t'{0, 8'h00, 0, 0, 10'h000, 0});
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, 1, tbl[i].clr, 0);
      check($sformatf("vec%0d_valid", i), key_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) check($sformatf("vec%0d_event", i), {key_ext, key_break, key_code}, tbl[i].e_ev);
      check($sformatf("vec%0d_kerr", i), stat_kbd_err, tbl[i].e_kerr);
    end

    // Timeout: a full TMO idle cycles abandons the E0 prefix
    step(1, 8'hE0, 1, 0, 0);
    repeat (TMO) step(0, 8'h00, 1, 0, 0);
    step(1, 8'h1C, 1, 0, 0);
    check("timeout_event", {key_valid, key_ext, key_break, key_code}, 11'h41C);
    // One idle cycle short of the timeout keeps the prefix
    step(1, 8'hE0, 1, 0, 0);
    repeat (TMO - 1) step(0, 8'h00, 1, 0, 0);
    step(1, 8'h1C, 1, 0, 0);
    check("no_timeout_event", {key_valid, key_ext, key_break, key_code}, 11'h61C);
    step(0, 8'h00, 1, 0, 0);

    // Overflow: DEPTH+1 makes with no consumer, then push+pop while full
    for (int i = 0; i <= DEPTH; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
    check("overflow_flag", stat_overflow, 1);
    step(1, 8'h30, 1, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) exp_d[i] = 8'h11 + 8'(i);
    exp_d[DEPTH-1] = 8'h30;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d", i), {key_valid, key_ext, key_break, key_code}, {3'b100, exp_d[i]});
      step(0, 8'h00, 1, 0, 0);
    end
    check("drained_empty", key_valid, 0);
    step(0, 8'h00, 0, 1, 0);
    check("overflow_cleared", stat_overflow, 0);

    // Reset mid-sequence with queued events
    step(1, 8'h1C, 0, 0, 0);
    step(1, 8'h2C, 0, 0, 0);
    step(1, 8'h3C, 0, 0, 0);
    step(1, 8'hF0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    check("rst_flush_valid", key_valid, 0);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h1C, 0, 0, 0);
    check("post_rst_event", {key_valid, key_ext, key_break, key_code}, 11'h41C);
    step(0, 8'h00, 1, 0, 0);

    // Random traffic against the reference model
    pool = '{8'h1C, 8'h75, 8'h14, 8'h77, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hE0, 8'hF0};
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 999));
      if (r < 15) begin
        repeat ($urandom_range(TMO - 2, TMO + 2)) step(0, 8'h00, $urandom_range(0, 1) == 1, 0, 0);
      end else if (r < 18) begin
        step(0, 8'h00, 0, 0, 1);
      end else if (r < 300) begin
        step(0, 8'h00, $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0, 0);
      end else begin
        b = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 11)] : 8'($urandom_range(0, 255));
        step(1, b, $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
